vga_pixel_fifo: RTL and testbench

Elastic pixel buffer directly upstream of the VGA timing/colour stage. Accepts a 24-bit RGB pixel stream with start-of-frame marker from a frame source (pattern generator or memory reader) over a valid/ready handshake. Serves one pixel per `pix_req` from the VGA stage, locked to that stage's `frame_start`. Detects and contains underflow and frame-length mismatches so a faulty source never shifts the picture.

---
 rtl/vga_pkg.sv | 14 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/vga_pixel_fifo.sv | 105 ++++++++++
 tb/tb_vga_pixel_fifo.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and control-state encoding for the VGA pixel path.
package vga_pkg;

  localparam int DATA_W   = 24;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SYNC,
    FILL,
    STREAM
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, synchronous flush and occupancy output.
module sync_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // The extra pointer bit separates full from empty when the address bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/vga_pixel_fifo.sv
// Elastic pixel buffer ahead of the VGA stage: locks source frames to the
// display's frame_start and contains underflow or frame-length faults.
module vga_pixel_fifo #(
  parameter int DATA_W   = vga_pkg::DATA_W,
  parameter int DEPTH    = 16,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_sof,
  output logic                     s_ready,
  input  logic                     frame_start,
  input  logic                     pix_req,
  output logic [DATA_W-1:0]        pix_data,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  import vga_pkg::*;

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = $clog2(TOTAL);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  pix_cnt;
  logic              ready;
  logic              wr_en;
  logic              rd_en;
  logic              flush;
  logic              serve;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .flush   (flush),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Once a frame is in flight, a new SOF beat is held on the bus until the
  // current frame ends so it can never be mixed into the wrong frame.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    flush      = 1'b0;
    case (state)
      SYNC: begin
        ready = 1'b1;
        wr_en = s_valid && s_sof;
        if (wr_en) next_state = FILL;
      end
      FILL: begin
        ready = !full && !(s_valid && s_sof);
        wr_en = s_valid && ready;
        if (frame_start) next_state = STREAM;
      end
      STREAM: begin
        ready = !full && !(s_valid && s_sof);
        wr_en = s_valid && ready;
        rd_en = pix_req;
        if (frame_start || (pix_req && pix_cnt == CNT_W'(TOTAL - 1))) begin
          flush      = 1'b1;
          next_state = SYNC;
        end
      end
      default: next_state = SYNC;
    endcase
  end

  assign s_ready = rst_n && ready;
  assign serve   = (state == STREAM) && pix_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SYNC;
      pix_cnt   <= '0;
      pix_data  <= '0;
      underflow <= 1'b0;
    end else begin
      state    <= next_state;
      pix_data <= (serve && !empty) ? head : '0;
      if (serve && empty) underflow <= 1'b1;
      if ((state == FILL && frame_start) || flush) pix_cnt <= '0;
      else if (serve)                              pix_cnt <= pix_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Table-driven bench for vga_pixel_fifo on a 4x2 frame with a pixel scoreboard.
module tb_vga_pixel_fifo;

  typedef struct packed {
    logic        valid;
    logic        sof;
    logic [23:0] data;
    logic        fs;
    logic        req;
    logic        keep;
    logic        serve;
    logic        rdy;
    logic [4:0]  lvl;
    logic        uf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [23:0] s_data;
  logic        s_sof;
  logic        s_ready;
  logic        frame_start;
  logic        pix_req;
  logic [23:0] pix_data;
  logic        underflow;
  logic [4:0]  fifo_level;

  int          n_vec;
  int          n_err;
  logic [23:0] sb[$];
  vec_t        tbl_a[$];
  vec_t        tbl_b[$];

  vga_pixel_fifo #(
    .DATA_W   (24),
    .DEPTH    (16),
    .H_ACTIVE (4),
    .V_ACTIVE (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .s_ready     (s_ready),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .underflow   (underflow),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic valid, input logic sof, input logic [23:0] data,
                              input logic fs, input logic req, input logic keep,
                              input logic serve, input logic rdy, input int lvl,
                              input logic uf);
    vec_t v;
    v.valid = valid; v.sof = sof; v.data = data; v.fs = fs; v.req = req;
    v.keep = keep; v.serve = serve; v.rdy = rdy; v.lvl = 5'(lvl); v.uf = uf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0; frame_start = 1'b0; pix_req = 1'b0;
  endtask

  // Ready is checked combinationally before the edge; data, level and underflow after it.
  task automatic apply(input vec_t v, input string name);
    logic [23:0] exp;
    s_valid = v.valid; s_sof = v.sof; s_data = v.data;
    frame_start = v.fs; pix_req = v.req;
    #1;
    check({name, ".s_ready"}, 32'(s_ready), 32'(v.rdy));
    if (v.keep) sb.push_back(v.data);
    exp = '0;
    if (v.serve) begin
      if (sb.size() == 0) check({name, ".scoreboard_nonempty"}, 0, 1);
      else exp = sb.pop_front();
    end
    @(posedge clk); #1;
    check({name, ".pix_data"}, 32'(pix_data), 32'(exp));
    check({name, ".fifo_level"}, 32'(fifo_level), 32'(v.lvl));
    check({name, ".underflow"}, 32'(underflow), 32'(v.uf));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Frame 1: SOF + 8 beats, frame_start, 8 requests, then a request while in SYNC.
    for (int i = 1; i <= 8; i++) tbl_a.push_back(mk(1, i == 1, 24'(i), 0, 0, 1, 0, 1, i, 0));
    tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 8, 0));
    for (int i = 1; i <= 8; i++) tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 8 - i, 0));
    tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    // Stray beats before SOF, a long frame (9 beats), next SOF held during STREAM.
    for (int i = 0; i < 3; i++) tbl_a.push_back(mk(1, 0, 24'hAA0000 + 24'(i), 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 9; i++) tbl_a.push_back(mk(1, i == 0, 24'h100 + 24'(i), 0, 0, i < 8, 0, 1, i + 1, 0));
    tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 9, 0));
    for (int i = 1; i <= 8; i++) tbl_a.push_back(mk(1, 1, 24'h200, 0, 1, 0, 1, 0, (i == 8) ? 0 : 9 - i, 0));
    // Held SOF accepted in SYNC; source stalls after 5 pixels.
    tbl_a.push_back(mk(1, 1, 24'h200, 0, 0, 1, 0, 1, 1, 0));
    for (int i = 1; i <= 4; i++) tbl_a.push_back(mk(1, 0, 24'h200 + 24'(i), 0, 0, 1, 0, 1, 1 + i, 0));
    tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 5, 0));
    for (int i = 1; i <= 5; i++) tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 5 - i, 0));
    for (int i = 6; i <= 8; i++) tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    // Resync on the next SOF, then fill to DEPTH mid-frame.
    tbl_a.push_back(mk(1, 1, 24'h300, 0, 0, 1, 0, 1, 1, 1));
    tbl_a.push_back(mk(1, 0, 24'h301, 0, 0, 1, 0, 1, 2, 1));
    tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 2, 1));
    tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 1));
    tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 1));
    for (int i = 0; i < 16; i++) tbl_a.push_back(mk(1, 0, 24'h500 + 24'(i), 0, 0, i == 0, 0, 1, i + 1, 1));
    tbl_a.push_back(mk(1, 0, 24'h5FF, 0, 1, 0, 1, 0, 15, 1));
    // After reset: short VGA frame (frame_start during STREAM) flushes back to SYNC.
    tbl_b.push_back(mk(1, 1, 24'h400, 0, 0, 1, 0, 1, 1, 0));
    tbl_b.push_back(mk(1, 0, 24'h401, 0, 0, 0, 0, 1, 2, 0));
    tbl_b.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 2, 0));
    tbl_b.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 0));
    tbl_b.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl_b.push_back(mk(1, 1, 24'h600, 0, 0, 0, 0, 1, 1, 0));

    idle();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst.s_ready_low", 32'(s_ready), 0);
    check("rst.pix_data", 32'(pix_data), 0);
    check("rst.fifo_level", 32'(fifo_level), 0);
    check("rst.underflow", 32'(underflow), 0);
    rst_n = 1'b1;
    #1;
    check("rst.s_ready_sync", 32'(s_ready), 1);

    for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], $sformatf("a%0d", i));

    // One-cycle reset while streaming with a full FIFO and a pending request.
    s_valid = 1'b1; s_sof = 1'b0; s_data = 24'h777777; pix_req = 1'b1; frame_start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst.s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    check("midrst.fifo_level", 32'(fifo_level), 0);
    check("midrst.pix_data", 32'(pix_data), 0);
    check("midrst.underflow", 32'(underflow), 0);
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], $sformatf("b%0d", i));

    check("scoreboard_drained", 32'(sb.size()), 0);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
